palette_mapper: RTL and testbench

Programmable, pipelined colour-code-to-RGB mapper for the Frogger VGA path. It sits between the sprite/background compositor, which produces a per-pixel colour code, and the VGA DAC outputs. A run-time-writable palette replaces the fixed nine-colour table and resets to the standard game colours. A two-stage registered pipeline adds blanking and a global dim control for pause and death screens.

---
 rtl/palette_pkg.sv | 31 +++
 rtl/palette_regfile.sv | 75 +++++++
 rtl/palette_mapper.sv | 94 +++++++++
 tb/tb_palette_mapper.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// Shared types and reset colours for the Frogger VGA palette mapper.
// The default table holds the 8-bit game colours; narrower or wider channels are derived from it.
package palette_pkg;

    localparam int CODE_W = 6;
    localparam int CHAN_W = 8;

    typedef struct packed {
        logic [CHAN_W-1:0] r;
        logic [CHAN_W-1:0] g;
        logic [CHAN_W-1:0] b;
    } rgb_t;

    localparam logic [CODE_W-1:0] C_WHITE  = 6'd0;
    localparam logic [CODE_W-1:0] C_BLACK  = 6'd1;
    localparam logic [CODE_W-1:0] C_GREEN  = 6'd2;
    localparam logic [CODE_W-1:0] C_RED    = 6'd3;
    localparam logic [CODE_W-1:0] C_LBLUE  = 6'd4;
    localparam logic [CODE_W-1:0] C_YELLOW = 6'd5;
    localparam logic [CODE_W-1:0] C_GREY   = 6'd6;
    localparam logic [CODE_W-1:0] C_ORANGE = 6'd7;
    localparam logic [CODE_W-1:0] C_BROWN  = 6'd8;

    localparam int N_DEFAULTS = 9;

    localparam rgb_t DEFAULT_PALETTE [N_DEFAULTS] = '{
        24'hffffff, 24'h000000, 24'h27b212, 24'hd80222, 24'h5db1f0,
        24'hf1ff0a, 24'hb2b2b0, 24'hf27a00, 24'h663300
    };

endpackage

// File: rtl/palette_regfile.sv
// Flop-based palette: synchronous reset to the game colours, one write port, one async read port.
// Out-of-range addresses are dropped on write and read back as black.
module palette_regfile
    import palette_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int CODE_W  = palette_pkg::CODE_W,
    parameter int CHAN_W  = palette_pkg::CHAN_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [CODE_W-1:0]   wr_addr,
    input  logic [3*CHAN_W-1:0] wr_rgb,
    input  logic [CODE_W-1:0]   rd_addr,
    output logic [3*CHAN_W-1:0] rd_rgb
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [3*CHAN_W-1:0] mem_r [ENTRIES];
    logic                wr_ok_s;
    logic                rd_ok_s;

    // Defaults keep the top CHAN_W bits of the 8-bit colour, zero-extended when wider.
    function automatic logic [CHAN_W-1:0] scale_chan(input logic [7:0] c8);
        logic [31:0] wide_s;
        wide_s = {24'h000000, c8};
        if (CHAN_W < 8) begin
            wide_s = wide_s >> (8 - CHAN_W);
        end else begin
            wide_s = wide_s;
        end
        return wide_s[CHAN_W-1:0];
    endfunction

    function automatic logic [3*CHAN_W-1:0] default_entry(input int idx);
        rgb_t d_s;
        if (idx < N_DEFAULTS) begin
            d_s = DEFAULT_PALETTE[idx];
        end else begin
            d_s = '0;
        end
        return {scale_chan(d_s.r), scale_chan(d_s.g), scale_chan(d_s.b)};
    endfunction

    function automatic logic in_range(input logic [CODE_W-1:0] addr);
        return ({1'b0, addr} < (CODE_W+1)'(ENTRIES));
    endfunction

    assign wr_ok_s = wr_en & in_range(wr_addr);
    assign rd_ok_s = in_range(rd_addr);

    // Palette storage: reset restores defaults, otherwise accept in-range writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_r[i] <= default_entry(i);
            end
        end else if (wr_ok_s) begin
            mem_r[wr_addr[IDX_W-1:0]] <= wr_rgb;
        end
    end

    // Asynchronous read with range check folded in.
    always_comb begin
        rd_rgb = '0;
        if (rd_ok_s) begin
            rd_rgb = mem_r[rd_addr[IDX_W-1:0]];
        end else begin
            rd_rgb = '0;
        end
    end

endmodule

// File: rtl/palette_mapper.sv
// Two-stage colour-code to RGB mapper: stage 1 registers the pixel, stage 2 looks up,
// applies blank/dim and registers the VGA outputs.
module palette_mapper
    import palette_pkg::*;
#(
    parameter int CODE_W  = palette_pkg::CODE_W,
    parameter int ENTRIES = 64,
    parameter int CHAN_W  = palette_pkg::CHAN_W
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                pix_valid,
    input  logic                blank,
    input  logic [CODE_W-1:0]   colorcode,
    input  logic [1:0]          dim,
    input  logic                wr_en,
    input  logic [CODE_W-1:0]   wr_addr,
    input  logic [3*CHAN_W-1:0] wr_rgb,
    output logic                out_valid,
    output logic [CHAN_W-1:0]   VGA_R,
    output logic [CHAN_W-1:0]   VGA_G,
    output logic [CHAN_W-1:0]   VGA_B
);

    logic                valid1_r;
    logic                blank1_r;
    logic [CODE_W-1:0]   code1_r;
    logic [1:0]          dim1_r;
    logic [3*CHAN_W-1:0] rd_rgb_s;
    logic [CHAN_W-1:0]   r_s;
    logic [CHAN_W-1:0]   g_s;
    logic [CHAN_W-1:0]   b_s;

    palette_regfile #(
        .ENTRIES (ENTRIES),
        .CODE_W  (CODE_W),
        .CHAN_W  (CHAN_W)
    ) u_regfile (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_rgb  (wr_rgb),
        .rd_addr (code1_r),
        .rd_rgb  (rd_rgb_s)
    );

    // Stage 1: capture the pixel request.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            valid1_r <= 1'b0;
            blank1_r <= 1'b0;
            code1_r  <= '0;
            dim1_r   <= 2'd0;
        end else begin
            valid1_r <= pix_valid;
            blank1_r <= blank;
            code1_r  <= colorcode;
            dim1_r   <= dim;
        end
    end

    // Stage 2 datapath: invalid or blanked slots are black, otherwise dimmed palette colour.
    always_comb begin
        r_s = '0;
        g_s = '0;
        b_s = '0;
        if (valid1_r && !blank1_r) begin
            r_s = rd_rgb_s[3*CHAN_W-1 -: CHAN_W] >> dim1_r;
            g_s = rd_rgb_s[2*CHAN_W-1 -: CHAN_W] >> dim1_r;
            b_s = rd_rgb_s[CHAN_W-1   -: CHAN_W] >> dim1_r;
        end else begin
            r_s = '0;
            g_s = '0;
            b_s = '0;
        end
    end

    // Stage 2: output registers.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            out_valid <= 1'b0;
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
        end else begin
            out_valid <= valid1_r;
            VGA_R     <= r_s;
            VGA_G     <= g_s;
            VGA_B     <= b_s;
        end
    end

endmodule

// File: tb/tb_palette_mapper.sv
// Directed bench for palette_mapper: defaults, write ordering, range, blank/dim, streaming, reset.
module tb_palette_mapper;
    import palette_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        pix_valid;
    logic        blank;
    logic [5:0]  colorcode;
    logic [1:0]  dim;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [23:0] wr_rgb;
    logic        out_valid;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        out_valid16;
    logic [7:0]  vga_r16, vga_g16, vga_b16;

    int n_cmp;
    int n_fail;

    palette_mapper dut (
        .Clk(clk), .Reset_n(reset_n), .pix_valid(pix_valid), .blank(blank),
        .colorcode(colorcode), .dim(dim), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_rgb(wr_rgb), .out_valid(out_valid), .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b)
    );

    palette_mapper #(.ENTRIES(16)) dut16 (
        .Clk(clk), .Reset_n(reset_n), .pix_valid(pix_valid), .blank(blank),
        .colorcode(colorcode), .dim(dim), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_rgb(wr_rgb), .out_valid(out_valid16), .VGA_R(vga_r16), .VGA_G(vga_g16), .VGA_B(vga_b16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_pix(input logic v, input logic b, input logic [5:0] c, input logic [1:0] d);
        pix_valid = v;
        blank     = b;
        colorcode = c;
        dim       = d;
    endtask

    task automatic test_reset;
        logic [23:0] exp_rgb;
        reset_n = 1'b0;
        wr_en = 1'b0; wr_addr = 6'd0; wr_rgb = 24'h000000;
        set_pix(1'b1, 1'b0, 6'd0, 2'd0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({out_valid, vga_r, vga_g, vga_b} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got valid=%b rgb=%h, want valid=0 rgb=000000", out_valid, {vga_r, vga_g, vga_b});
        end
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i < 2) begin
                n_cmp++;
                if ({out_valid, vga_r, vga_g, vga_b} !== 25'd0) begin
                    n_fail++;
                    $display("FAIL reset_release_%0d: got valid=%b rgb=%h, want 0", i, out_valid, {vga_r, vga_g, vga_b});
                end
            end else begin
                exp_rgb = (i - 2 < 9) ? DEFAULT_PALETTE[i - 2] : 24'h000000;
                n_cmp++;
                if (out_valid !== 1'b1 || {vga_r, vga_g, vga_b} !== exp_rgb) begin
                    n_fail++;
                    $display("FAIL default_code%0d: got valid=%b rgb=%h, want valid=1 rgb=%h", i - 2, out_valid, {vga_r, vga_g, vga_b}, exp_rgb);
                end
            end
            if (i < 10) set_pix(1'b1, 1'b0, 6'(i), 2'd0);
            else        set_pix(1'b0, 1'b0, 6'd0, 2'd0);
            @(negedge clk);
        end
    endtask

    task automatic test_write_read;
        set_pix(1'b1, 1'b0, 6'd12, 2'd0);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 6'd12; wr_rgb = 24'h123456;
        set_pix(1'b1, 1'b0, 6'd12, 2'd0);
        @(negedge clk);
        wr_en = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || {vga_r, vga_g, vga_b} !== 24'h000000) begin
            n_fail++;
            $display("FAIL write_old_value: got valid=%b rgb=%h, want valid=1 rgb=000000", out_valid, {vga_r, vga_g, vga_b});
        end
        set_pix(1'b0, 1'b0, 6'd0, 2'd0);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || {vga_r, vga_g, vga_b} !== 24'h123456) begin
            n_fail++;
            $display("FAIL write_new_value: got valid=%b rgb=%h, want valid=1 rgb=123456", out_valid, {vga_r, vga_g, vga_b});
        end
        @(negedge clk);
    endtask

    task automatic test_range;
        wr_en = 1'b1; wr_addr = 6'd20; wr_rgb = 24'habcdef;
        set_pix(1'b0, 1'b0, 6'd0, 2'd0);
        @(negedge clk);
        wr_en = 1'b0;
        set_pix(1'b1, 1'b0, 6'd20, 2'd0);
        @(negedge clk);
        set_pix(1'b1, 1'b0, 6'd4, 2'd0);
        @(negedge clk);
        set_pix(1'b0, 1'b0, 6'd0, 2'd0);
        n_cmp++;
        if (out_valid !== 1'b1 || {vga_r, vga_g, vga_b} !== 24'habcdef) begin
            n_fail++;
            $display("FAIL range64_code20: got valid=%b rgb=%h, want valid=1 rgb=abcdef", out_valid, {vga_r, vga_g, vga_b});
        end
        n_cmp++;
        if (out_valid16 !== 1'b1 || {vga_r16, vga_g16, vga_b16} !== 24'h000000) begin
            n_fail++;
            $display("FAIL range16_code20: got valid=%b rgb=%h, want valid=1 rgb=000000", out_valid16, {vga_r16, vga_g16, vga_b16});
        end
        @(negedge clk);
        n_cmp++;
        if ({vga_r16, vga_g16, vga_b16} !== 24'h5db1f0) begin
            n_fail++;
            $display("FAIL range16_alias_code4: got rgb=%h, want rgb=5db1f0", {vga_r16, vga_g16, vga_b16});
        end
        @(negedge clk);
    endtask

    task automatic test_blank_dim;
        logic [5:0]  codes [6] = '{6'd0, 6'd0, 6'd3, 6'd0, 6'd0, 6'd8};
        logic        blnk  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0]  dims  [6] = '{2'd0, 2'd1, 2'd3, 2'd3, 2'd3, 2'd2};
        logic [23:0] expv  [6] = '{24'h000000, 24'h7f7f7f, 24'h1b0004, 24'h1f1f1f, 24'h000000, 24'h190c00};
        for (int i = 0; i < 8; i++) begin
            if (i >= 2) begin
                n_cmp++;
                if (out_valid !== 1'b1 || {vga_r, vga_g, vga_b} !== expv[i - 2]) begin
                    n_fail++;
                    $display("FAIL blank_dim_%0d: got valid=%b rgb=%h, want valid=1 rgb=%h", i - 2, out_valid, {vga_r, vga_g, vga_b}, expv[i - 2]);
                end
            end
            if (i < 6) set_pix(1'b1, blnk[i], codes[i], dims[i]);
            else       set_pix(1'b0, 1'b0, 6'd0, 2'd0);
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        logic        v;
        logic [23:0] exp_rgb;
        for (int i = 0; i < 11; i++) begin
            if (i >= 2) begin
                v = ((i - 2) % 2 == 0);
                exp_rgb = v ? DEFAULT_PALETTE[i - 2] : 24'h000000;
                n_cmp++;
                if (out_valid !== v || {vga_r, vga_g, vga_b} !== exp_rgb) begin
                    n_fail++;
                    $display("FAIL stream_slot%0d: got valid=%b rgb=%h, want valid=%b rgb=%h", i - 2, out_valid, {vga_r, vga_g, vga_b}, v, exp_rgb);
                end
            end
            if (i < 9) set_pix((i % 2 == 0), 1'b0, 6'(i), 2'd0);
            else       set_pix(1'b0, 1'b0, 6'd0, 2'd0);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        wr_en = 1'b1; wr_addr = 6'd2; wr_rgb = 24'h0a0b0c;
        set_pix(1'b0, 1'b0, 6'd0, 2'd0);
        @(negedge clk);
        wr_en = 1'b0;
        set_pix(1'b1, 1'b0, 6'd2, 2'd0);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || {vga_r, vga_g, vga_b} !== 24'h0a0b0c) begin
            n_fail++;
            $display("FAIL mid_overwritten: got valid=%b rgb=%h, want valid=1 rgb=0a0b0c", out_valid, {vga_r, vga_g, vga_b});
        end
        reset_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, vga_r, vga_g, vga_b} !== 25'd0) begin
            n_fail++;
            $display("FAIL mid_reset_clear: got valid=%b rgb=%h, want 0", out_valid, {vga_r, vga_g, vga_b});
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, vga_r, vga_g, vga_b} !== 25'd0) begin
            n_fail++;
            $display("FAIL mid_flush: got valid=%b rgb=%h, want 0", out_valid, {vga_r, vga_g, vga_b});
        end
        set_pix(1'b0, 1'b0, 6'd0, 2'd0);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || {vga_r, vga_g, vga_b} !== 24'h27b212) begin
            n_fail++;
            $display("FAIL mid_default_restored: got valid=%b rgb=%h, want valid=1 rgb=27b212", out_valid, {vga_r, vga_g, vga_b});
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_write_read();
        test_range();
        test_blank_dim();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
